// File: rtl/sram_1rw1r_wmask.sv
// Synchronous SRAM: port 0 is read/write with byte mask, port 1 is read-only, and reset zero-fills the array.
// Define SRAM_WR_FWD_EN so that a port 1 read colliding with a port 0 write returns the new word.
`timescale 1ns/1ps
module sram_1rw1r_wmask #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int unsigned WMASK_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   busy
);

    typedef enum logic {StClear, StReady} state_e;

    localparam logic [ADDR_WIDTH-1:0] PtrLast = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  ready;
    logic                  wr_en, rd0_en, rd1_en;
    logic [DATA_WIDTH-1:0] rd1_word;

    assign ready  = (state_q == StReady);
    assign busy   = (state_q == StClear);
    assign wr_en  = ready && !csb0 && !web0;
    assign rd0_en = ready && !csb0 && web0;
    assign rd1_en = ready && !csb1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == StClear) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            if (ptr_q == PtrLast) begin
                state_d = StReady;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Port 1 sees the array before this edge's write unless forwarding is built in.
    always_comb begin
        rd1_word = mem[addr1];
`ifdef SRAM_WR_FWD_EN
        if (wr_en && (addr0 == addr1)) begin
            for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
                if (wmask0[i]) begin
                    rd1_word[8*i +: 8] = din0[8*i +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (state_q == StClear) begin
                mem[ptr_q] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
                    if (wmask0[i]) begin
                        mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0 || (state_q == StClear)) begin
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            if (rd0_en) begin
                dout0 <= mem[addr0];
            end
            if (rd1_en) begin
                dout1 <= rd1_word;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk0) begin
        if (!rst0 && ready) begin
            if (!csb0 && ($isunknown(addr0) || (!web0 && $isunknown(din0)))) begin
                $display("%0t sram warning: X/Z on port 0 address or data", $time);
            end
            if (!csb1 && $isunknown(addr1)) begin
                $display("%0t sram warning: X/Z on port 1 address", $time);
            end
            if (wr_en) begin
                $display("%0t sram p0 write addr=%0d data=%h mask=%b", $time, addr0, din0,
                         wmask0);
            end
            if (rd0_en) begin
                $display("%0t sram p0 read  addr=%0d data=%h", $time, addr0, mem[addr0]);
            end
            if (rd1_en) begin
                $display("%0t sram p1 read  addr=%0d data=%h", $time, addr1, rd1_word);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed bench for sram_1rw1r_wmask: a word-array model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_sram_1rw1r_wmask;

    localparam int DEPTH = 64;

    logic        clk0;
    logic        rst0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [5:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        csb1;
    logic [5:0]  addr1;
    logic [31:0] dout1;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    sram_1rw1r_wmask dut (
        .clk0   (clk0),
        .rst0   (rst0),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .csb1   (csb1),
        .addr1  (addr1),
        .dout1  (dout1),
        .busy   (busy)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain word array plus a count of words still to be cleared.
    logic [31:0] mmem [DEPTH];
    logic [31:0] exp0, exp1, old1, neww;
    int          clr_left = 0;
    bit          live = 0;

    initial begin
        forever begin
            @(posedge clk0);
            if (rst0) begin
                exp0     = 0;
                exp1     = 0;
                clr_left = DEPTH;
                live     = 1;
            end else if (clr_left > 0) begin
                mmem[DEPTH - clr_left] = 0;
                clr_left--;
            end else begin
                old1 = mmem[addr1];
                neww = mmem[addr0];
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) neww[8*b +: 8] = din0[8*b +: 8];
                end
                if (!csb0 && web0) exp0 = mmem[addr0];
                if (!csb1) begin
                    exp1 = old1;
`ifdef SRAM_WR_FWD_EN
                    if (!csb0 && !web0 && addr0 == addr1) exp1 = neww;
`endif
                end
                if (!csb0 && !web0) mmem[addr0] = neww;
            end
            #1;
            if (live) begin
                check("busy", {31'b0, busy}, {31'b0, clr_left > 0});
                check("dout0", dout0, exp0);
                check("dout1", dout1, exp1);
            end
        end
    end

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'h0;
        csb1   = 1'b1;
    endtask

    // Counts cycles with busy high, starting from the cycle after reset release.
    task automatic count_busy(input bit poke, output int cnt);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            cnt++;
            if (poke && cnt == 10) begin
                csb0 = 1'b0; web0 = 1'b0; addr0 = 6'd3; din0 = 32'h55; wmask0 = 4'hf;
                csb1 = 1'b0; addr1 = 6'd3;
            end else begin
                idle();
            end
            @(negedge clk0);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        @(negedge clk0);
        idle();
    endtask

    task automatic rd0(input logic [5:0] a, output logic [31:0] v);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
        @(posedge clk0); #2;
        v = dout0;
        @(negedge clk0);
        idle();
    endtask

    task automatic rd1(input logic [5:0] a, output logic [31:0] v);
        csb1 = 1'b0; addr1 = a;
        @(posedge clk0); #2;
        v = dout1;
        @(negedge clk0);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cnt;
        logic [31:0] v;
        rst0 = 1'b1; addr0 = 0; addr1 = 0; din0 = 0;
        idle();
        repeat (2) @(posedge clk0);
        #2;
        check("reset_dout0", dout0, 32'h0);
        check("reset_dout1", dout1, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h1);
        @(negedge clk0);
        rst0 = 1'b0;
        count_busy(1'b1, cnt);
        check("clear_cycles", cnt, 32'd64);

        rd1(6'd0, v);  check("clear_addr0", v, 32'h0);
        rd1(6'd31, v); check("clear_addr31", v, 32'h0);
        rd1(6'd63, v); check("clear_addr63", v, 32'h0);
        rd0(6'd3, v);  check("busy_write_ignored", v, 32'h0);

        wr(6'd5, 32'hAABBCCDD, 4'b1111);
        wr(6'd5, 32'h11223344, 4'b0101);
        rd0(6'd5, v);  check("byte_mask", v, 32'hAA22CC44);
        wr(6'd5, 32'hFFFFFFFF, 4'b0000);
        rd0(6'd5, v);  check("mask_zero_noop", v, 32'hAA22CC44);

        wr(6'd63, 32'hDEADBEEF, 4'hf);
        wr(6'd0, 32'h12345678, 4'hf);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 6'd63;
        csb1 = 1'b0; addr1 = 6'd0;
        @(posedge clk0); #2;
        check("dual_dout0", dout0, 32'hDEADBEEF);
        check("dual_dout1", dout1, 32'h12345678);
        @(negedge clk0);
        idle();

        csb0 = 1'b0; web0 = 1'b0; addr0 = 6'd7; din0 = 32'hFFFFFFFF; wmask0 = 4'b0011;
        csb1 = 1'b0; addr1 = 6'd7;
        @(posedge clk0); #2;
`ifdef SRAM_WR_FWD_EN
        check("collision_dout1", dout1, 32'h0000FFFF);
`else
        check("collision_dout1", dout1, 32'h00000000);
`endif
        check("write_holds_dout0", dout0, 32'hDEADBEEF);
        @(negedge clk0);
        idle();
        rd1(6'd7, v);  check("after_collision", v, 32'h0000FFFF);

        @(negedge clk0);
        check("csb_hold_dout0", dout0, 32'hDEADBEEF);
        check("csb_hold_dout1", dout1, 32'h0000FFFF);

        rst0 = 1'b1;
        repeat (2) @(negedge clk0);
        rst0 = 1'b0;
        repeat (20) @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        rst0 = 1'b0;
        count_busy(1'b0, cnt);
        check("midclear_cycles", cnt, 32'd64);
        check("midclear_dout0", dout0, 32'h0);
        rd1(6'd5, v);  check("midclear_addr5", v, 32'h0);
        rd0(6'd63, v); check("midclear_addr63", v, 32'h0);

        repeat (2) @(negedge clk0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
